// File: rtl/adder_pkg.sv
// Shared definitions for the time-shared multi-precision adder.
package adder_pkg;

   localparam int unsigned SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   // Slice index width; a one-slice build still needs a 1-bit counter.
   function automatic int unsigned idx_width(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/RippleCarryAdder_16bit.sv
// 16-bit ripple-carry adder slice built from explicit full-adder cells.
module RippleCarryAdder_16bit
   import adder_pkg::*;
(
   input  logic [SLICE_W-1:0] in1,
   input  logic [SLICE_W-1:0] in2,
   input  logic               c_in,
   output logic [SLICE_W-1:0] sum,
   output logic               c_out
);

   logic [SLICE_W:0] w_carry;

   assign w_carry[0] = c_in;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      logic w_p;
      assign w_p            = in1[i] ^ in2[i];
      assign sum[i]         = w_p ^ w_carry[i];
      assign w_carry[i + 1] = (in1[i] & in2[i]) | (w_p & w_carry[i]);
   end

   assign c_out = w_carry[SLICE_W];

endmodule

// File: rtl/multiword_adder_seq.sv
// Multi-precision add/subtract that walks one 16-bit slice per clock through a single
// shared ripple-carry adder, least-significant slice first.
module multiword_adder_seq
   import adder_pkg::*;
#(
   parameter  int unsigned WORDS = 4,
   localparam int unsigned W     = SLICE_W * WORDS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic [W-1:0] in1,
   input  logic [W-1:0] in2,
   input  logic         c_in,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         c_out
);

   localparam int unsigned        IDX_W    = idx_width(WORDS);
   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORDS - 1);

   seq_state_t                     r_state;
   seq_state_t                     w_state_next;

   logic [WORDS-1:0][SLICE_W-1:0] r_a;
   logic [WORDS-1:0][SLICE_W-1:0] r_b;
   logic [WORDS-1:0][SLICE_W-1:0] r_sum;
   logic                          r_carry;
   logic                          r_c_out;
   logic [IDX_W-1:0]              r_idx;

   logic                          w_accept;
   logic                          w_last;
   logic [SLICE_W-1:0]            w_a_slice;
   logic [SLICE_W-1:0]            w_b_slice;
   logic [SLICE_W-1:0]            w_slice_sum;
   logic                          w_slice_carry;

   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last   = (r_idx == LAST_IDX);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_next = ADD;
         ADD:     if (w_last) w_state_next = DONE;
         DONE:    w_state_next = start ? ADD : IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // busy/done decode straight from the state register, so they are glitch-free.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (r_state)
         ADD:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------- slice select
   always_comb begin
      w_a_slice = '0;
      w_b_slice = '0;
      for (int k = 0; k < int'(WORDS); k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_a_slice = r_a[k];
            w_b_slice = r_b[k];
         end
      end
   end

   RippleCarryAdder_16bit u_slice_adder (
      .in1   (w_a_slice),
      .in2   (w_b_slice),
      .c_in  (r_carry),
      .sum   (w_slice_sum),
      .c_out (w_slice_carry)
   );

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_c_out <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         // Subtraction is a + ~b + 1, so the inversion and the +1 are folded in here.
         r_a     <= in1;
         r_b     <= sub ? ~in2 : in2;
         r_carry <= sub ? 1'b1 : c_in;
         r_sum   <= '0;
         r_idx   <= '0;
      end else if (r_state == ADD) begin
         for (int k = 0; k < int'(WORDS); k++) begin
            if (r_idx == IDX_W'(k)) begin
               r_sum[k] <= w_slice_sum;
            end
         end
         r_carry <= w_slice_carry;
         if (w_last) begin
            r_c_out <= w_slice_carry;
            r_idx   <= '0;
         end else begin
            r_idx   <= r_idx + IDX_W'(1);
         end
      end
   end

   assign sum   = r_sum;
   assign c_out = r_c_out;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Scoreboard bench for multiword_adder_seq at WORDS=4 and WORDS=1.
module tb_multiword_adder_seq;

   typedef struct packed {
      logic [63:0] s;
      logic        c;
   } exp_t;

   logic        clk;
   logic        rst_n;

   logic        start4, sub4, c_in4, busy4, done4, c_out4;
   logic [63:0] in1_4, in2_4, sum4;

   logic        start1, sub1, c_in1, busy1, done1, c_out1;
   logic [15:0] in1_1, in2_1, sum1;

   int          n_checks;
   int          n_fail;
   int          dcnt4;
   int          dcnt1;
   exp_t        q4[$];
   exp_t        q1[$];

   multiword_adder_seq #(.WORDS(4)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .sub   (sub4),
      .in1   (in1_4),
      .in2   (in2_4),
      .c_in  (c_in4),
      .busy  (busy4),
      .done  (done4),
      .sum   (sum4),
      .c_out (c_out4)
   );

   multiword_adder_seq #(.WORDS(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start1),
      .sub   (sub1),
      .in1   (in1_1),
      .in2   (in2_1),
      .c_in  (c_in1),
      .busy  (busy1),
      .done  (done1),
      .sum   (sum1),
      .c_out (c_out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic ci,
                                  input logic s, input int w);
      logic [64:0] r;
      logic [63:0] mask;
      exp_t        e;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      if (s) r = {1'b0, a & mask} + {1'b0, ~b & mask} + 65'd1;
      else   r = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, ci};
      e.s = r[63:0] & mask;
      e.c = r[w];
      return e;
   endfunction

   // Result monitors: pop on each done pulse, sampled on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (done4) begin
         dcnt4++;
         check_eq("excl4", {63'd0, busy4}, 64'd0);
         if (q4.size() == 0) begin
            check_eq("sb4_underflow", 64'(q4.size()), 64'd1);
         end else begin
            e = q4.pop_front();
            check_eq("sum4", sum4, e.s);
            check_eq("cout4", {63'd0, c_out4}, {63'd0, e.c});
         end
      end
      if (done1) begin
         dcnt1++;
         check_eq("excl1", {63'd0, busy1}, 64'd0);
         if (q1.size() == 0) begin
            check_eq("sb1_underflow", 64'(q1.size()), 64'd1);
         end else begin
            e = q1.pop_front();
            check_eq("sum1", {48'd0, sum1}, e.s);
            check_eq("cout1", {63'd0, c_out1}, {63'd0, e.c});
         end
      end
   end

   task automatic wait_done4(output int n, output int nb);
      n  = 0;
      nb = 0;
      while (!done4 && n < 20) begin
         if (busy4) nb++;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run4(input logic [63:0] a, input logic [63:0] b, input logic ci,
                       input logic s);
      int n, nb;
      @(negedge clk);
      in1_4 = a; in2_4 = b; c_in4 = ci; sub4 = s; start4 = 1'b1;
      q4.push_back(model(a, b, ci, s, 64));
      @(negedge clk);
      start4 = 1'b0;
      in1_4 = '1; in2_4 = '1; sub4 = ~s;
      wait_done4(n, nb);
      check_eq("lat4", 64'(n), 64'd4);
      check_eq("busy_cycles4", 64'(nb), 64'd4);
      @(negedge clk);
      check_eq("done_drop4", {63'd0, done4}, 64'd0);
   endtask

   task automatic run1(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic s);
      int n, nb;
      @(negedge clk);
      in1_1 = a; in2_1 = b; c_in1 = ci; sub1 = s; start1 = 1'b1;
      q1.push_back(model({48'd0, a}, {48'd0, b}, ci, s, 16));
      @(negedge clk);
      start1 = 1'b0;
      n  = 0;
      nb = 0;
      while (!done1 && n < 20) begin
         if (busy1) nb++;
         @(negedge clk);
         n++;
      end
      check_eq("lat1", 64'(n), 64'd1);
      check_eq("busy_cycles1", 64'(nb), 64'd1);
      @(negedge clk);
      check_eq("done_drop1", {63'd0, done1}, 64'd0);
   endtask

   initial begin
      int n, nb, d0;
      n_checks = 0; n_fail = 0; dcnt4 = 0; dcnt1 = 0;
      rst_n  = 1'b0;
      start4 = 1'b0; sub4 = 1'b0; c_in4 = 1'b0; in1_4 = '0; in2_4 = '0;
      start1 = 1'b0; sub1 = 1'b0; c_in1 = 1'b0; in1_1 = '0; in2_1 = '0;

      repeat (2) @(negedge clk);
      check_eq("rst_busy4", {63'd0, busy4}, 64'd0);
      check_eq("rst_done4", {63'd0, done4}, 64'd0);
      check_eq("rst_sum4", sum4, 64'd0);
      check_eq("rst_cout4", {63'd0, c_out4}, 64'd0);
      check_eq("rst_busy1", {63'd0, busy1}, 64'd0);
      check_eq("rst_sum1", {48'd0, sum1}, 64'd0);
      rst_n = 1'b1;

      run4(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
      run4(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
      run4(64'd5, 64'd7, 1'b0, 1'b1);
      run4(64'd7, 64'd5, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         run4({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      end

      run1(16'd25001, 16'd40535, 1'b0, 1'b0);
      run1(16'd3245, 16'd16785, 1'b1, 1'b0);
      run1(16'd100, 16'd200, 1'b0, 1'b1);

      // start during ADD must be ignored
      d0 = dcnt4;
      @(negedge clk);
      in1_4 = 64'h1234_5678_9ABC_DEF0; in2_4 = 64'h0FED_CBA9_8765_4321;
      c_in4 = 1'b1; sub4 = 1'b0; start4 = 1'b1;
      q4.push_back(model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 64));
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      in1_4 = 64'd1; in2_4 = 64'd1; sub4 = 1'b1; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      wait_done4(n, nb);
      check_eq("busy_ignore_done", {63'd0, done4}, 64'd1);
      @(negedge clk);
      check_eq("busy_ignore_queue", 64'(q4.size()), 64'd0);
      check_eq("busy_ignore_pulses", 64'(dcnt4 - d0), 64'd1);
      check_eq("busy_ignore_idle", {63'd0, busy4}, 64'd0);

      // reset after two ADD cycles discards the partial result
      @(negedge clk);
      in1_4 = 64'hFFFF_FFFF_FFFF_FFFF; in2_4 = 64'd3; c_in4 = 1'b0; sub4 = 1'b0;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_busy", {63'd0, busy4}, 64'd0);
      check_eq("midrst_done", {63'd0, done4}, 64'd0);
      check_eq("midrst_sum", sum4, 64'd0);
      check_eq("midrst_cout", {63'd0, c_out4}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run4(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b0, 1'b0);

      // back-to-back: second start issued in the DONE cycle of the first
      d0 = dcnt4;
      @(negedge clk);
      in1_4 = 64'h0000_FFFF_0000_FFFF; in2_4 = 64'h0000_0001_0000_0001;
      c_in4 = 1'b0; sub4 = 1'b0; start4 = 1'b1;
      q4.push_back(model(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 64));
      @(negedge clk);
      start4 = 1'b0;
      wait_done4(n, nb);
      check_eq("b2b_lat_a", 64'(n), 64'd4);
      in1_4 = 64'd10; in2_4 = 64'd3; c_in4 = 1'b0; sub4 = 1'b1; start4 = 1'b1;
      q4.push_back(model(64'd10, 64'd3, 1'b0, 1'b1, 64));
      @(negedge clk);
      start4 = 1'b0;
      check_eq("b2b_busy", {63'd0, busy4}, 64'd1);
      check_eq("b2b_done_fell", {63'd0, done4}, 64'd0);
      wait_done4(n, nb);
      check_eq("b2b_lat_b", 64'(n), 64'd4);
      @(negedge clk);
      check_eq("b2b_pulses", 64'(dcnt4 - d0), 64'd2);

      repeat (3) @(negedge clk);
      check_eq("q4_empty", 64'(q4.size()), 64'd0);
      check_eq("q1_empty", 64'(q1.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
